vc_input_unit: RTL

- Router input-port block that drives one row of `wavefront_allocator`: it generates `vc_request` and `vc_target_port`, and consumes that row's `vc_grant_final`.
- Buffers incoming flits in per-VC FIFOs and latches each packet's output route from its head flit.
- Tracks downstream credits per VC, forwards granted flits to the crossbar, and returns credits upstream.
- Instantiated PORT_NUM times per router, one per input port.

---
 rtl/noc_params.sv | 27 ++
 rtl/vc_input_unit_if.sv | 36 +++
 rtl/vc_fifo.sv | 52 +++++
 rtl/vc_input_unit.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/noc_params.sv
// noc_params: shared router types (output ports, flit layout, VC state).
package noc_params;

   localparam int PORT_NUM  = 5;
   localparam int PAYLOAD_W = 16;

   typedef enum logic [2:0] {
      LOCAL = 3'd0,
      NORTH = 3'd1,
      SOUTH = 3'd2,
      EAST  = 3'd3,
      WEST  = 3'd4
   } port_t;

   typedef struct packed {
      logic                 head;
      logic                 tail;
      port_t                dest;
      logic [PAYLOAD_W-1:0] payload;
   } flit_t;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } vc_state_t;

endpackage

// File: rtl/vc_input_unit_if.sv
// vc_input_unit_if: flit input, allocator row, crossbar output and credit
// signals of one router input port. master = surrounding router, slave = unit.
interface vc_input_unit_if
   import noc_params::*;
#(
   parameter int VC_NUM = 2
);
   localparam int VC_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

   logic                  in_valid;
   logic [VC_W-1:0]       in_vc;
   flit_t                 in_flit;
   logic                  credit_out_valid;
   logic [VC_W-1:0]       credit_out_vc;
   logic [VC_NUM-1:0]     vc_request;
   port_t [VC_NUM-1:0]    vc_target_port;
   logic [VC_NUM-1:0]     vc_grant;
   logic                  xbar_valid;
   port_t                 xbar_port;
   flit_t                 xbar_flit;
   logic                  credit_in_valid;
   logic [VC_W-1:0]       credit_in_vc;

   modport master (
      output in_valid, in_vc, in_flit, vc_grant, credit_in_valid, credit_in_vc,
      input  credit_out_valid, credit_out_vc, vc_request, vc_target_port,
             xbar_valid, xbar_port, xbar_flit
   );

   modport slave (
      input  in_valid, in_vc, in_flit, vc_grant, credit_in_valid, credit_in_vc,
      output credit_out_valid, credit_out_vc, vc_request, vc_target_port,
             xbar_valid, xbar_port, xbar_flit
   );

endinterface

// File: rtl/vc_fifo.sv
// vc_fifo: single-VC circular flit buffer. Pointers carry one extra wrap bit
// so full and empty are distinguishable. A write to a full buffer is accepted
// only when a pop happens in the same cycle; otherwise it is dropped.
module vc_fifo
   import noc_params::*;
#(
   parameter int DEPTH = 4
) (
   input  logic  clk,
   input  logic  RSTn,
   input  logic  i_wr_en,
   input  flit_t i_wr_data,
   input  logic  i_rd_en,
   output logic  o_full,
   output logic  o_empty,
   output flit_t o_front
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;
   flit_t       r_mem [DEPTH];
   logic        w_push;
   logic        w_pop;

   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop   = i_rd_en && !o_empty;
   assign w_push  = i_wr_en && (!o_full || w_pop);
   // Empty buffer presents an all-zero flit so downstream sees dest LOCAL.
   assign o_front = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

   // Flit storage write port.
   // NOTE: storage has no reset; the pointers alone define which slots are valid.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
   end

   // Pointer advance on accepted push / pop.
   // NOTE: sequential state uses <= so every register updates from pre-edge values.
   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/vc_input_unit.sv
// vc_input_unit: router input port. Buffers flits per VC, latches the route
// from each head flit, requests the switch allocator, forwards granted flits
// to the crossbar one cycle later and returns credits upstream.
// Optional macro VC_INPUT_UNIT_ERR_FLAG_EN adds a sticky err_flag output.
module vc_input_unit
   import noc_params::*;
#(
   parameter int VC_NUM      = 2,
   parameter int BUF_DEPTH   = 4,
   parameter int CREDIT_INIT = 4
) (
   input logic            clk,
   input logic            RSTn,
   vc_input_unit_if.slave vc_bus
`ifdef VC_INPUT_UNIT_ERR_FLAG_EN
   ,
   output logic           err_flag
`endif
);
   localparam int VC_W  = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
   localparam int CRD_W = $clog2(CREDIT_INIT + 1);

   logic [VC_NUM-1:0]  w_wr, w_full, w_empty, w_pop, w_req, w_vgrant, w_cinc;
   flit_t              w_front  [VC_NUM];
   port_t              w_target [VC_NUM];
   vc_state_t          r_state  [VC_NUM];
   port_t              r_route  [VC_NUM];
   logic [CRD_W-1:0]   r_credit [VC_NUM];
   logic               w_any;
   logic [VC_W-1:0]    w_sel;

   logic               r_xbar_valid;
   port_t              r_xbar_port;
   flit_t              r_xbar_flit;
   logic               r_credit_out_valid;
   logic [VC_W-1:0]    r_credit_out_vc;

   for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
      vc_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
         .clk       (clk),
         .RSTn      (RSTn),
         .i_wr_en   (w_wr[v]),
         .i_wr_data (vc_bus.in_flit),
         .i_rd_en   (w_pop[v]),
         .o_full    (w_full[v]),
         .o_empty   (w_empty[v]),
         .o_front   (w_front[v])
      );
   end

   // Per-VC write/credit decode, requests, target ports and lowest-index grant pick.
   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      w_wr   = '0;
      w_cinc = '0;
      w_req  = '0;
      w_pop  = '0;
      w_any  = 1'b0;
      w_sel  = '0;
      for (int v = 0; v < VC_NUM; v++) begin
         w_wr[v]     = vc_bus.in_valid && (vc_bus.in_vc == VC_W'(v));
         w_cinc[v]   = vc_bus.credit_in_valid && (vc_bus.credit_in_vc == VC_W'(v));
         w_req[v]    = !w_empty[v] && (r_credit[v] != '0) &&
                       ((r_state[v] == ACTIVE) || w_front[v].head);
         w_target[v] = (r_state[v] == ACTIVE) ? r_route[v] : w_front[v].dest;
      end
      w_vgrant = vc_bus.vc_grant & w_req;
      for (int v = VC_NUM - 1; v >= 0; v--) begin
         if (w_vgrant[v]) begin
            w_any = 1'b1;
            w_sel = VC_W'(v);
         end
      end
      if (w_any) w_pop[w_sel] = 1'b1;
   end

   // Allocator-facing outputs.
   always_comb begin
      for (int v = 0; v < VC_NUM; v++) vc_bus.vc_target_port[v] = w_target[v];
   end
   assign vc_bus.vc_request = w_req;

   // Per-VC packet state, route latch and downstream credit counters.
   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         for (int v = 0; v < VC_NUM; v++) begin
            r_state[v]  <= IDLE;
            r_route[v]  <= LOCAL;
            r_credit[v] <= CRD_W'(CREDIT_INIT);
         end
      end else begin
         for (int v = 0; v < VC_NUM; v++) begin
            if (w_pop[v]) begin
               if (r_state[v] == IDLE && w_front[v].head && !w_front[v].tail) begin
                  r_state[v] <= ACTIVE;
                  r_route[v] <= w_front[v].dest;
               end else if (r_state[v] == ACTIVE && w_front[v].tail) begin
                  r_state[v] <= IDLE;
               end
            end
            // Simultaneous pop and credit return cancel; increments saturate.
            if (w_pop[v] && !w_cinc[v])
               r_credit[v] <= r_credit[v] - 1'b1;
            else if (!w_pop[v] && w_cinc[v] && r_credit[v] != CRD_W'(CREDIT_INIT))
               r_credit[v] <= r_credit[v] + 1'b1;
         end
      end
   end

   // Registered crossbar and upstream credit outputs, one cycle after the grant.
   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         r_xbar_valid       <= 1'b0;
         r_xbar_port        <= LOCAL;
         r_xbar_flit        <= '0;
         r_credit_out_valid <= 1'b0;
         r_credit_out_vc    <= '0;
      end else begin
         r_xbar_valid       <= w_any;
         r_credit_out_valid <= w_any;
         if (w_any) begin
            r_xbar_flit     <= w_front[w_sel];
            r_xbar_port     <= w_target[w_sel];
            r_credit_out_vc <= w_sel;
         end
      end
   end

   assign vc_bus.xbar_valid       = r_xbar_valid;
   assign vc_bus.xbar_port        = r_xbar_port;
   assign vc_bus.xbar_flit        = r_xbar_flit;
   assign vc_bus.credit_out_valid = r_credit_out_valid;
   assign vc_bus.credit_out_vc    = r_credit_out_vc;

`ifdef VC_INPUT_UNIT_ERR_FLAG_EN
   logic w_err_evt;
   logic r_err;

   // Protocol-violation detect: dropped write, credit overflow, stalled IDLE VC.
   always_comb begin
      w_err_evt = 1'b0;
      for (int v = 0; v < VC_NUM; v++) begin
         if (w_wr[v] && w_full[v] && !w_pop[v]) w_err_evt = 1'b1;
         if (w_cinc[v] && !w_pop[v] && r_credit[v] == CRD_W'(CREDIT_INIT)) w_err_evt = 1'b1;
         if (r_state[v] == IDLE && !w_empty[v] && !w_front[v].head) w_err_evt = 1'b1;
      end
   end

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn)          r_err <= 1'b0;
      else if (w_err_evt) r_err <= 1'b1;
   end

   assign err_flag = r_err;
`endif

endmodule
